// File: rtl/bmp_accel_pkg.sv
// rtl/bmp_accel_pkg.sv - shared types and saturating lane helpers for the BMP stream accelerator
package bmp_accel_pkg;

    typedef enum logic [1:0] {PASS = 2'd0, ADD = 2'd1, SUB = 2'd2, THR = 2'd3} mode_e;
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_e;

    // Lane values travel zero-extended in 32 bits; c is the lane width in bits.
    function automatic logic [31:0] lane_max(input int c);
        logic [32:0] m;
        m = (33'd1 << c) - 33'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] p, input int c);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, p};
        return (s > {1'b0, lane_max(c)}) ? lane_max(c) : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] p, input int c);
        return (a >= p) ? (a - p) & lane_max(c) : 32'd0;
    endfunction

    function automatic logic [31:0] thresh(input logic [31:0] a, input logic [31:0] p, input int c);
        return (a >= p) ? lane_max(c) : 32'd0;
    endfunction

endpackage

// File: rtl/bmp_out_fifo.sv
// rtl/bmp_out_fifo.sv - synchronous show-ahead output FIFO with occupancy count
module bmp_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    // Head is masked while empty so stale storage never reaches the master port.
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bmp_stream_accelerator.sv
// rtl/bmp_stream_accelerator.sv - round-robin multi-slave BMP pixel accelerator with output FIFO
module bmp_stream_accelerator
    import bmp_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = 8,
    parameter int NUM_SLV    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int SRC_W = $clog2(NUM_SLV),
    localparam int LANES = DATA_WIDTH / COLOR_SIZE,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2*NUM_SLV-1:0]             slv_mode,
    input  logic [NUM_SLV-1:0]               slv_data_valid,
    input  logic [NUM_SLV-1:0]               slv_last,
    input  logic [COLOR_SIZE*NUM_SLV-1:0]    slv_proc_val,
    input  logic [DATA_WIDTH*NUM_SLV-1:0]    slv_data,
    output logic [NUM_SLV-1:0]               slv_rdy,
    input  logic                             mstr_rdy,
    output logic [DATA_WIDTH-1:0]            mstr_data,
    output logic                             mstr_data_valid,
    output logic [SRC_W-1:0]                 mstr_src,
    output logic                             mstr_cmplt
);

    state_e                  state;
    mode_e                   mode_q;
    logic [COLOR_SIZE-1:0]   proc_q;
    logic [SRC_W-1:0]        grant_q;
    logic [SRC_W-1:0]        rr_ptr;
    logic                    pipe_vld;
    logic [DATA_WIDTH-1:0]   pipe_data;
    logic                    cmplt_q;
    logic [CNT_W-1:0]        fifo_count;
    logic [SRC_W-1:0]        arb_idx;
    logic                    arb_found;
    int                      arb_cand;
    logic                    room;
    logic                    accept;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [DATA_WIDTH-1:0]   lane_res;

    // Search starts one past the last grant so every requester is served in turn.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        arb_cand  = 0;
        for (int k = 1; k <= NUM_SLV; k++) begin
            arb_cand = (int'(rr_ptr) + k) % NUM_SLV;
            if (!arb_found && slv_data_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = SRC_W'(arb_cand);
            end
        end
    end

    // Words already in flight in the pipe count against FIFO space.
    assign room   = (int'(fifo_count) + int'(pipe_vld)) < FIFO_DEPTH;
    assign accept = (state == STREAM) && room && slv_data_valid[grant_q];
    assign pop    = mstr_data_valid && mstr_rdy;

    always_comb begin
        slv_rdy = '0;
        if (state == STREAM && room) begin
            slv_rdy[grant_q] = 1'b1;
        end
    end

    assign sel_data = slv_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0] lane_in;
        logic [31:0] lane_out;
        always_comb begin
            lane_in = 32'(sel_data[g*COLOR_SIZE +: COLOR_SIZE]);
            case (mode_q)
                ADD:     lane_out = sat_add(lane_in, 32'(proc_q), COLOR_SIZE);
                SUB:     lane_out = sat_sub(lane_in, 32'(proc_q), COLOR_SIZE);
                THR:     lane_out = thresh(lane_in, 32'(proc_q), COLOR_SIZE);
                default: lane_out = lane_in;
            endcase
        end
        assign lane_res[g*COLOR_SIZE +: COLOR_SIZE] = lane_out[COLOR_SIZE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= PASS;
            proc_q    <= '0;
            grant_q   <= '0;
            rr_ptr    <= SRC_W'(NUM_SLV - 1);
            pipe_vld  <= 1'b0;
            pipe_data <= '0;
            cmplt_q   <= 1'b0;
        end else begin
            cmplt_q  <= 1'b0;
            pipe_vld <= accept;
            if (accept) begin
                pipe_data <= lane_res;
            end
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_q <= arb_idx;
                        rr_ptr  <= arb_idx;
                        mode_q  <= mode_e'(slv_mode[2*int'(arb_idx) +: 2]);
                        proc_q  <= slv_proc_val[int'(arb_idx)*COLOR_SIZE +: COLOR_SIZE];
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept && slv_last[grant_q]) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The image is done once the pipe is empty and the final FIFO word leaves.
                    if (!pipe_vld && fifo_count == CNT_W'(1) && pop) begin
                        state   <= IDLE;
                        cmplt_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    bmp_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_vld),
        .push_data (pipe_data),
        .pop       (mstr_rdy),
        .head      (mstr_data),
        .valid     (mstr_data_valid),
        .count     (fifo_count)
    );

    assign mstr_src   = grant_q;
    assign mstr_cmplt = cmplt_q;

endmodule

// File: tb/tb_bmp_stream_accelerator.sv
// tb/tb_bmp_stream_accelerator.sv - directed self-checking bench for bmp_stream_accelerator
module tb_bmp_stream_accelerator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  slv_mode;
    logic [1:0]  slv_data_valid;
    logic [1:0]  slv_last;
    logic [15:0] slv_proc_val;
    logic [63:0] slv_data;
    logic [1:0]  slv_rdy;
    logic        mstr_rdy;
    logic [31:0] mstr_data;
    logic        mstr_data_valid;
    logic [0:0]  mstr_src;
    logic        mstr_cmplt;

    logic [31:0] sd [2];
    logic [1:0]  sm [2];
    logic [7:0]  sp [2];
    logic        sv [2];
    logic        sl [2];
    logic [31:0] img [2][16];

    assign slv_data       = {sd[1], sd[0]};
    assign slv_mode       = {sm[1], sm[0]};
    assign slv_proc_val   = {sp[1], sp[0]};
    assign slv_data_valid = {sv[1], sv[0]};
    assign slv_last       = {sl[1], sl[0]};

    bmp_stream_accelerator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .slv_mode        (slv_mode),
        .slv_data_valid  (slv_data_valid),
        .slv_last        (slv_last),
        .slv_proc_val    (slv_proc_val),
        .slv_data        (slv_data),
        .slv_rdy         (slv_rdy),
        .mstr_rdy        (mstr_rdy),
        .mstr_data       (mstr_data),
        .mstr_data_valid (mstr_data_valid),
        .mstr_src        (mstr_src),
        .mstr_cmplt      (mstr_cmplt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmplt_cnt;
    int first_rx_cyc;
    int rdy1_first;
    int onehot_err;
    int acc_cnt [2];
    int acc_cyc [2];
    logic [31:0] rx_data [$];
    logic        rx_src [$];
    int          pop_cyc [$];
    int          cm_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mstr_data_valid && mstr_rdy) begin
                rx_data.push_back(mstr_data);
                rx_src.push_back(mstr_src[0]);
                pop_cyc.push_back(cyc);
                if (first_rx_cyc < 0) first_rx_cyc = cyc;
            end
            if (mstr_cmplt) begin
                cmplt_cnt = cmplt_cnt + 1;
                cm_cyc.push_back(cyc);
            end
            if (slv_rdy[1] && rdy1_first < 0) rdy1_first = cyc;
            if (slv_rdy == 2'b11) onehot_err = onehot_err + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rx_data.delete();
        rx_src.delete();
        pop_cyc.delete();
        cm_cyc.delete();
        cmplt_cnt    = 0;
        first_rx_cyc = -1;
        rdy1_first   = -1;
        onehot_err   = 0;
        acc_cnt[0]   = 0;
        acc_cnt[1]   = 0;
        acc_cyc[0]   = -1;
        acc_cyc[1]   = -1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        sv[0] = 1'b0; sv[1] = 1'b0; sl[0] = 1'b0; sl[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
    endtask

    task automatic drive_image(input int s, input logic [1:0] m, input logic [7:0] p, input int n);
        int i = 0;
        int guard = 0;
        @(posedge clk);
        #1;
        sm[s] = m; sp[s] = p; sd[s] = img[s][0]; sl[s] = (n == 1); sv[s] = 1'b1;
        while (i < n && guard < 300) begin
            @(negedge clk);
            guard++;
            if (slv_rdy[s]) begin
                acc_cnt[s] = acc_cnt[s] + 1;
                acc_cyc[s] = cyc;
                i++;
            end
            @(posedge clk);
            #1;
            if (i < n) begin
                sd[s] = img[s][i];
                sl[s] = (i == n - 1);
            end else begin
                sv[s] = 1'b0;
                sl[s] = 1'b0;
            end
        end
        if (i < n) begin
            check($sformatf("drv%0d_timeout", s), 64'(i), 64'(n));
            sv[s] = 1'b0;
            sl[s] = 1'b0;
        end
    endtask

    task automatic wait_cmplt(input int target);
        int guard = 0;
        while (cmplt_cnt < target && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (cmplt_cnt < target) check("cmplt_timeout", 64'(cmplt_cnt), 64'(target));
    endtask

    initial begin
        int n;
        int g;
        logic [31:0] d0;
        rst_n = 1'b0;
        mstr_rdy = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sd[s] = '0; sm[s] = '0; sp[s] = '0; sv[s] = 1'b0; sl[s] = 1'b0;
        end
        clear_log();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(mstr_data_valid), 64'd0);
        check("rst_data", 64'(mstr_data), 64'd0);
        check("rst_rdy", 64'(slv_rdy), 64'd0);
        check("rst_cmplt", 64'(mstr_cmplt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset while streaming with three words parked in the FIFO
        @(posedge clk);
        #1 sd[0] = 32'h11111111; sm[0] = 2'd0; sv[0] = 1'b1; sl[0] = 1'b0;
        n = 0; g = 0;
        while (n < 4 && g < 30) begin
            @(negedge clk);
            g++;
            if (slv_rdy[0]) n++;
        end
        check("t1_accepts", 64'(n), 64'd4);
        @(negedge clk);
        check("t1_pre_valid", 64'(mstr_data_valid), 64'd1);
        check("t1_pre_rdy", 64'(slv_rdy), 64'd0);
        #2 rst_n = 1'b0;
        sv[0] = 1'b0;
        #1;
        check("t1_valid", 64'(mstr_data_valid), 64'd0);
        check("t1_data", 64'(mstr_data), 64'd0);
        check("t1_rdy", 64'(slv_rdy), 64'd0);
        check("t1_src", 64'(mstr_src), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
        repeat (2) @(negedge clk);
        check("t1_post_empty", 64'(mstr_data_valid), 64'd0);

        // Saturating add on slave 0
        mstr_rdy = 1'b1;
        img[0][0] = 32'h10F0E000;
        img[0][1] = 32'hFFFFFFFF;
        drive_image(0, 2'd1, 8'h20, 2);
        wait_cmplt(1);
        check("t2_cnt", 64'(rx_data.size()), 64'd2);
        check("t2_w0", 64'(rx_data[0]), 64'h30FFFF20);
        check("t2_w1", 64'(rx_data[1]), 64'hFFFFFFFF);
        check("t2_src", 64'(rx_src[1]), 64'd0);
        check("t2_cmplt_cyc", 64'(cm_cyc[0]), 64'(pop_cyc[1] + 1));

        // Saturating subtract and threshold
        clear_log();
        img[0][0] = 32'h7F80FF00;
        drive_image(0, 2'd2, 8'h80, 1);
        wait_cmplt(1);
        drive_image(0, 2'd3, 8'h80, 1);
        wait_cmplt(2);
        check("t5_sub", 64'(rx_data[0]), 64'h00007F00);
        check("t5_thr", 64'(rx_data[1]), 64'h00FFFF00);

        // Round-robin between two simultaneous requesters
        do_reset();
        for (int k = 0; k < 3; k++) begin
            img[0][k] = 32'hA0 + k;
            img[1][k] = 32'hB0 + k;
        end
        fork
            drive_image(0, 2'd0, 8'h00, 3);
            drive_image(1, 2'd0, 8'h00, 3);
        join
        wait_cmplt(2);
        fork
            drive_image(0, 2'd0, 8'h00, 3);
            drive_image(1, 2'd0, 8'h00, 3);
        join
        wait_cmplt(4);
        check("t3_cnt", 64'(rx_data.size()), 64'd12);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_a%0d", k), 64'(rx_data[k]), 64'(img[0][k]));
            check($sformatf("t3_b%0d", k), 64'(rx_data[k+3]), 64'(img[1][k]));
        end
        check("t3_src_a", 64'(rx_src[2]), 64'd0);
        check("t3_src_b", 64'(rx_src[3]), 64'd1);
        check("t3_r2_first", 64'(rx_data[6]), 64'hA0);
        check("t3_r2_src", 64'(rx_src[6]), 64'd0);
        check("t3_r2_b", 64'(rx_data[9]), 64'hB0);
        check("t3_onehot", 64'(onehot_err), 64'd0);

        // Backpressure fills the FIFO and stalls the slave
        clear_log();
        mstr_rdy = 1'b0;
        for (int k = 0; k < 8; k++) img[0][k] = 32'h40 + k;
        fork
            drive_image(0, 2'd0, 8'h00, 8);
        join_none
        repeat (20) @(negedge clk);
        check("t4_accepts", 64'(acc_cnt[0]), 64'd4);
        check("t4_rdy", 64'(slv_rdy), 64'd0);
        d0 = mstr_data;
        check("t4_head", 64'(d0), 64'h40);
        repeat (3) @(negedge clk);
        check("t4_stable", 64'(mstr_data), 64'(d0));
        @(posedge clk);
        #1 mstr_rdy = 1'b1;
        wait_cmplt(1);
        check("t4_cnt", 64'(rx_data.size()), 64'd8);
        for (int k = 0; k < 8; k++) check($sformatf("t4_w%0d", k), 64'(rx_data[k]), 64'(img[0][k]));

        // Single-word image with a second slave waiting
        do_reset();
        img[0][0] = 32'hDEADBEEF;
        img[1][0] = 32'h12345678;
        fork
            drive_image(0, 2'd0, 8'h00, 1);
            drive_image(1, 2'd0, 8'h00, 1);
        join
        wait_cmplt(2);
        check("t6_w0", 64'(rx_data[0]), 64'hDEADBEEF);
        check("t6_lat", 64'(first_rx_cyc), 64'(acc_cyc[0] + 2));
        check("t6_cmplt", 64'(cm_cyc[0]), 64'(acc_cyc[0] + 3));
        check("t6_next_grant", 64'(rdy1_first), 64'(cm_cyc[0] + 1));
        check("t6_w1", 64'(rx_data[1]), 64'h12345678);
        check("t6_src1", 64'(rx_src[1]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
